wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter: SP_RESET, 32'h0000_0FFC, reset value of register $29.
REQ-002 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: w_reg_ctl  in  1  writeback enable from MEM/WB register.
REQ-005 SHALL have: mem_to_reg  in  2  writeback source select.
REQ-006 SHALL have: mem_data  in  32  load data from MEM/WB.
REQ-007 SHALL have: alu_result  in  32  ALU result from MEM/WB.
REQ-008 SHALL have: pc_value  in  32  link address from MEM/WB, already PC+4.
REQ-009 SHALL have: w_reg_addr  in  5  destination register index.
REQ-010 SHALL have: rs_addr  in  5  read port A index (ID stage).
REQ-011 SHALL have: rt_addr  in  5  read port B index (ID stage).
REQ-012 SHALL have: rs_data  out  32  read port A data.
REQ-013 SHALL have: rt_data  out  32  read port B data.
REQ-014 SHALL have: wb_data  out  32  selected writeback value, for forwarding.
REQ-015 SHALL have: wb_en  out  1  effective write strobe: w_reg_ctl AND w_reg_addr != 0.
REQ-016 SHALL have: wb_count  out  32  registered count of retired effective writes.

Function
REQ-017 SHALL select wb_data combinationally: mem_to_reg 0 -> alu_result, 1 -> mem_data, 2 -> pc_value, 3 -> alu_result (reserved).
REQ-018 SHALL hold 32 x 32-bit registers; register 0 SHALL read as 0 at all times and SHALL never be written.
REQ-019 SHALL write wb_data into register w_reg_addr on the rising edge when wb_en=1 and reset=0; one-cycle write latency.
REQ-020 SHALL read rs_data/rt_data combinationally from the array, zero latency.
REQ-021 SHALL bypass: when wb_en=1 and rs_addr (rt_addr) equals w_reg_addr, rs_data (rt_data) SHALL equal current wb_data in the same cycle.
REQ-022 SHALL apply bypass independently to both ports; rs_addr = rt_addr = w_reg_addr SHALL return wb_data on both.
REQ-023 SHALL suppress bypass and write when w_reg_ctl=0, regardless of mem_to_reg or address.
REQ-024 SHALL increment wb_count by 1 each edge with wb_en=1; wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-025 SHALL ignore w_reg_addr=0 writes entirely: no array change, no count increment, no bypass.

Reset
REQ-026 SHALL, on any edge with reset=1, clear registers 1-28 and 30-31 to 0, load register 29 with SP_RESET, clear wb_count to 0.
REQ-027 SHALL give reset priority over a simultaneous write: write discarded, count not incremented.
REQ-028 SHALL keep wb_data, wb_en and read outputs combinational during reset; read ports reflect array (bypass active if wb_en=1).
REQ-029 SHALL resume normal writes on the first edge with reset=0; mid-operation reset discards no more than the coincident write.

Verification
REQ-030 Reset: reset=1 one edge, read all 32 indices -> $29=32'h0000_0FFC, all others 0, wb_count=0.
REQ-031 Source mux: w_reg_addr=8, alu_result=32'h11, mem_data=32'h22, pc_value=32'h33, mem_to_reg=0/1/2/3 over four cycles, rs_addr=8 after each -> 32'h11, 32'h22, 32'h33, 32'h11; wb_count=4.
REQ-032 Bypass: w_reg_ctl=1, w_reg_addr=5, alu_result=32'hDEAD_BEEF, rs_addr=rt_addr=5 same cycle -> rs_data=rt_data=32'hDEAD_BEEF before the edge; reg 5 holds it after.
REQ-033 Zero register: w_reg_ctl=1, w_reg_addr=0, alu_result=32'hFFFF_FFFF, rs_addr=0 -> rs_data=0 before and after edge, wb_en=0, wb_count unchanged.
REQ-034 Disabled write: w_reg_ctl=0, w_reg_addr=7, rs_addr=7 (reg 7 previously 32'h5) -> rs_data=32'h5 before and after edge.
REQ-035 Reset collision: reset=1 with w_reg_ctl=1, w_reg_addr=9, alu_result=32'hABCD -> reg 9 = 0 and wb_count = 0 after the edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-stage register file: selects the writeback value, writes it into
// a 32 x 32 array and serves two combinational read ports. A port whose
// index matches the destination in the writing cycle gets the writeback
// value directly, so ID-stage reads never see a stale register. wb_count
// tracks how many effective writes have retired.
module wb_regfile #(
   parameter logic [31:0] SP_RESET = 32'h0000_0FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_reg_ctl,
   input  logic [1:0]  mem_to_reg,
   input  logic [31:0] mem_data,
   input  logic [31:0] alu_result,
   input  logic [31:0] pc_value,
   input  logic [4:0]  w_reg_addr,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] wb_data,
   output logic        wb_en,
   output logic [31:0] wb_count
);

   // Writeback source encoding; code 3 is reserved and behaves like ALU.
   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_PC   = 2'd2,
      SRC_RSVD = 2'd3
   } wb_src_e;

   localparam int unsigned SP_INDEX = 29;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic [31:0] wb_count_q;
   logic [31:0] wb_count_d;

   // Writeback source mux.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wb_data = alu_result;
      unique case (wb_src_e'(mem_to_reg))
         SRC_ALU:  wb_data = alu_result;
         SRC_MEM:  wb_data = mem_data;
         SRC_PC:   wb_data = pc_value;
         SRC_RSVD: wb_data = alu_result;
         default:  wb_data = alu_result;
      endcase
   end

   // Register 0 is hard-wired, so a write aimed at it is not a write at all.
   assign wb_en    = w_reg_ctl && (w_reg_addr != 5'd0);
   assign wb_count = wb_count_q;

   // Next state of the array and the retired-write counter.
   always_comb begin
      regs_d = regs_q;
      if (wb_en) begin
         regs_d[w_reg_addr] = wb_data;
      end
      // Keeps entry 0 at zero even before the first reset clears it.
      regs_d[0]  = '0;
      wb_count_d = wb_count_q + (wb_en ? 32'd1 : 32'd0);
   end

   // State registers; reset wins over a coincident write.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: this array is reset on purpose because software relies on $29 holding the
         // initial stack pointer; plain storage arrays are normally left unreset.
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
         end
         wb_count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
      end
   end

   // Read ports: zero register, then same-cycle bypass, then the array.
   always_comb begin
      rs_data = regs_q[rs_addr];
      rt_data = regs_q[rt_addr];
      if (rs_addr == 5'd0) begin
         rs_data = '0;
      end else if (wb_en && (rs_addr == w_reg_addr)) begin
         rs_data = wb_data;
      end
      if (rt_addr == 5'd0) begin
         rt_data = '0;
      end else if (wb_en && (rt_addr == w_reg_addr)) begin
         rt_data = wb_data;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. Each cycle pushes the expected read
// data, writeback value, strobe and count into a scoreboard, then pops and
// compares them against the DUT once the inputs have settled.
module tb_wb_regfile;

   localparam logic [31:0] SP = 32'h0000_0FFC;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_reg_ctl;
   logic [1:0]  mem_to_reg;
   logic [31:0] mem_data;
   logic [31:0] alu_result;
   logic [31:0] pc_value;
   logic [4:0]  w_reg_addr;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data;
   logic        wb_en;
   logic [31:0] wb_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_regs [32];
   logic [31:0] model_count;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   wb_regfile #(.SP_RESET(SP)) dut (
      .clk        (clk),
      .reset      (reset),
      .w_reg_ctl  (w_reg_ctl),
      .mem_to_reg (mem_to_reg),
      .mem_data   (mem_data),
      .alu_result (alu_result),
      .pc_value   (pc_value),
      .w_reg_addr (w_reg_addr),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wb_data    (wb_data),
      .wb_en      (wb_en),
      .wb_count   (wb_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [31:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", obs, ~obs);
      end else begin
         check(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_regs[i] = (i == 29) ? SP : 32'd0;
      model_count = 32'd0;
   endtask

   function automatic logic [31:0] sel_value(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] mem, input logic [31:0] pc);
      case (sel)
         2'd1:    return mem;
         2'd2:    return pc;
         default: return alu;
      endcase
   endfunction

   // One clock cycle: drive, predict, compare before the edge, then clock and update the model.
   task automatic cycle(input string name, input logic rst, input logic ctl, input logic [1:0] sel,
                        input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [4:0] ra, input logic [4:0] rb);
      logic [31:0] e_wb;
      logic        e_en;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      @(negedge clk);
      reset = rst; w_reg_ctl = ctl; mem_to_reg = sel; w_reg_addr = wa;
      alu_result = alu; mem_data = mem; pc_value = pc; rs_addr = ra; rt_addr = rb;
      e_wb = sel_value(sel, alu, mem, pc);
      e_en = ctl && (wa != 5'd0);
      e_rs = (ra == 5'd0) ? 32'd0 : (e_en && ra == wa) ? e_wb : model_regs[ra];
      e_rt = (rb == 5'd0) ? 32'd0 : (e_en && rb == wa) ? e_wb : model_regs[rb];
      push_exp({name, "_rs"}, e_rs);
      push_exp({name, "_rt"}, e_rt);
      push_exp({name, "_wbdata"}, e_wb);
      push_exp({name, "_wben"}, {31'd0, e_en});
      push_exp({name, "_count"}, model_count);
      #1;
      pop_check(rs_data);
      pop_check(rt_data);
      pop_check(wb_data);
      pop_check({31'd0, wb_en});
      pop_check(wb_count);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (e_en) begin
         model_regs[wa] = e_wb;
         model_count    = model_count + 32'd1;
      end
   endtask

   initial begin
      reset = 1'b1; w_reg_ctl = 1'b0; mem_to_reg = 2'd0; mem_data = '0;
      alu_result = '0; pc_value = '0; w_reg_addr = '0; rs_addr = '0; rt_addr = '0;
      @(posedge clk);
      model_reset();

      // Reset state: every index through both ports.
      for (int i = 0; i < 32; i++) begin
         cycle("rst_read", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
      end

      // Source mux into register 8, read back after each write.
      for (int s = 0; s < 4; s++) begin
         cycle("mux_wr", 1'b0, 1'b1, 2'(s), 5'd8, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2);
         cycle("mux_rd", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd29);
      end
      check("mux_final_count", wb_count, 32'd4);

      // Same-cycle bypass on both ports, then array holds the value.
      cycle("bypass", 1'b0, 1'b1, 2'd0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd5);
      cycle("bypass_after", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5);
      check("bypass_reg5", rs_data, 32'hDEAD_BEEF);

      // Zero register is never written, bypassed or counted.
      cycle("zero_wr", 1'b0, 1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
      cycle("zero_after", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);

      // Disabled write leaves register 7 alone and does not bypass.
      cycle("r7_set", 1'b0, 1'b1, 2'd1, 5'd7, 32'h0, 32'h5, 32'h0, 5'd0, 5'd0);
      cycle("dis_wr", 1'b0, 1'b0, 2'd0, 5'd7, 32'h1234, 32'h9999, 32'h0, 5'd7, 5'd7);
      cycle("dis_after", 1'b0, 1'b0, 2'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);

      // Reset collides with a write; bypass still visible during reset.
      cycle("pre_col", 1'b0, 1'b1, 2'd0, 5'd9, 32'h77, 32'h0, 32'h0, 5'd9, 5'd29);
      cycle("rst_col", 1'b1, 1'b1, 2'd0, 5'd9, 32'hABCD, 32'h0, 32'h0, 5'd9, 5'd5);
      cycle("col_after", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd29);
      check("col_count", wb_count, 32'd0);
      cycle("resume", 1'b0, 1'b1, 2'd2, 5'd9, 32'h0, 32'h0, 32'h400, 5'd3, 5'd4);
      cycle("resume_rd", 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd29);

      // Random traffic with frequent address collisions and rare resets.
      for (int n = 0; n < 300; n++) begin
         logic [4:0] wa;
         logic [4:0] ra;
         logic [4:0] rb;
         wa = 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), wa, $urandom, $urandom, $urandom, ra, rb);
      end

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
